reg_file_2r1w: RTL and testbench

- Parametrised register file for the MIPS datapath: one write port, two independent read ports.
- Synchronous registered reads, byte-lane writes, optional hardwired-zero entry 0.
- Sits between the decode stage (reads rs/rt) and writeback (one write per cycle).
- Replaces the single-port tristate register block; all outputs are point-to-point, with no Z drive.

---
 rtl/reg_file_pkg.sv | 23 ++
 rtl/reg_file_rd_port.sv | 56 +++++
 rtl/reg_file_2r1w.sv | 89 ++++++++
 tb/tb_reg_file_2r1w.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and the byte-lane merge helper for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int unsigned WordSizeDef  = 32;
  localparam int unsigned AddrWidthDef = 5;
  localparam int unsigned NumLanesDef  = WordSizeDef / 8;

  // Widest word the merge helper supports; callers zero-extend in and truncate out.
  localparam int unsigned MaxWord  = 512;
  localparam int unsigned MaxLanes = MaxWord / 8;

  function automatic logic [MaxWord-1:0] byte_merge(input logic [MaxWord-1:0]  old_w,
                                                    input logic [MaxWord-1:0]  new_w,
                                                    input logic [MaxLanes-1:0] be);
    logic [MaxWord-1:0] merged;
    merged = old_w;
    for (int i = 0; i < int'(MaxLanes); i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: address-0 masking, optional write-first bypass (REG_FILE_BYPASS_EN).
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WordSizeDef,
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  on_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [WORD_SIZE-1:0]  stored_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0]  wr_word_i,
  output logic [WORD_SIZE-1:0]  rdata_o,
  output logic                  rvalid_o
);

  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rvalid_q;

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rdata_d = stored_i;
    if (we_i && (waddr_i == raddr_i)) rdata_d = wr_word_i;
    if (ZERO_REG && (raddr_i == '0)) rdata_d = '0;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{we_i, waddr_i, wr_word_i};

  always_comb begin
    rdata_d = stored_i;
    if (ZERO_REG && (raddr_i == '0)) rdata_d = '0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (on_i && re_i) begin
      rdata_q  <= rdata_d;
      rvalid_q <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file, one byte-lane write port and two registered read ports.
// Define REG_FILE_BYPASS_EN for write-first same-address reads; default is read-first.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WordSizeDef,
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ON,
  input  logic                   WE,
  input  logic [ADDR_WIDTH-1:0]  WADDR,
  input  logic [WORD_SIZE-1:0]   WDATA,
  input  logic [WORD_SIZE/8-1:0] WBE,
  input  logic                   RE_A,
  input  logic [ADDR_WIDTH-1:0]  RADDR_A,
  output logic [WORD_SIZE-1:0]   RDATA_A,
  output logic                   RVALID_A,
  input  logic                   RE_B,
  input  logic [ADDR_WIDTH-1:0]  RADDR_B,
  output logic [WORD_SIZE-1:0]   RDATA_B,
  output logic                   RVALID_B
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam int unsigned NumLanes = WORD_SIZE / 8;

  logic [WORD_SIZE-1:0] mem_q [Depth];
  logic [WORD_SIZE-1:0] wr_merged;
  logic [WORD_SIZE-1:0] stored_a, stored_b;
  logic                 wr_en;
  logic                 wr_act;

  assign wr_merged = WORD_SIZE'(byte_merge(MaxWord'(mem_q[WADDR]), MaxWord'(WDATA),
                                           MaxLanes'(WBE[NumLanes-1:0])));
  assign wr_act    = ON && WE;
  // Entry 0 is never written when hardwired, so it stays at its reset value of zero.
  assign wr_en     = wr_act && !(ZERO_REG && (WADDR == '0));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[WADDR] <= wr_merged;
    end
  end

  assign stored_a = mem_q[RADDR_A];
  assign stored_b = mem_q[RADDR_B];

  reg_file_rd_port #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_rd_a (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .on_i     (ON),
    .re_i     (RE_A),
    .raddr_i  (RADDR_A),
    .stored_i (stored_a),
    .we_i     (wr_act),
    .waddr_i  (WADDR),
    .wr_word_i(wr_merged),
    .rdata_o  (RDATA_A),
    .rvalid_o (RVALID_A)
  );

  reg_file_rd_port #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_rd_b (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .on_i     (ON),
    .re_i     (RE_B),
    .raddr_i  (RADDR_B),
    .stored_i (stored_b),
    .we_i     (wr_act),
    .waddr_i  (WADDR),
    .wr_word_i(wr_merged),
    .rdata_o  (RDATA_B),
    .rvalid_o (RVALID_B)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: behavioural model checked every cycle plus literal spot checks.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n, on, we, re_a, re_b;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [3:0]  wbe;

  // Index 0/1: ports A/B of the hardwired-zero instance; 2/3: ports A/B of the plain one.
  logic [31:0] rd  [4];
  logic        rv  [4];
  logic [31:0] exp_rd [4];
  logic        exp_rv [4];
  logic [31:0] mem [2][32];

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WORD_SIZE(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut_z (
    .CLK(clk), .RST_N(rst_n), .ON(on), .WE(we), .WADDR(waddr), .WDATA(wdata), .WBE(wbe),
    .RE_A(re_a), .RADDR_A(raddr_a), .RDATA_A(rd[0]), .RVALID_A(rv[0]),
    .RE_B(re_b), .RADDR_B(raddr_b), .RDATA_B(rd[1]), .RVALID_B(rv[1])
  );

  reg_file_2r1w #(.WORD_SIZE(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut_n (
    .CLK(clk), .RST_N(rst_n), .ON(on), .WE(we), .WADDR(waddr), .WDATA(wdata), .WBE(wbe),
    .RE_A(re_a), .RADDR_A(raddr_a), .RDATA_A(rd[2]), .RVALID_A(rv[2]),
    .RE_B(re_b), .RADDR_B(raddr_b), .RDATA_B(rd[3]), .RVALID_B(rv[3])
  );

  function automatic logic [31:0] merged(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] model_read(input int m, input logic [4:0] a);
    logic [31:0] v;
    if (m == 0 && a == 5'd0) return 32'h0;
    v = mem[m][a];
`ifdef REG_FILE_BYPASS_EN
    if (we && waddr == a) v = merged(v, wdata, wbe);
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 32; a++) mem[m][a] = 32'h0;
      for (int p = 0; p < 4; p++) begin
        exp_rd[p] = 32'h0;
        exp_rv[p] = 1'b0;
      end
    end else if (on) begin
      for (int p = 0; p < 4; p++) begin
        if ((p % 2 == 0) ? re_a : re_b) begin
          exp_rd[p] = model_read(p / 2, (p % 2 == 0) ? raddr_a : raddr_b);
          exp_rv[p] = 1'b1;
        end else begin
          exp_rv[p] = 1'b0;
        end
      end
      if (we) begin
        if (waddr != 5'd0) mem[0][waddr] = merged(mem[0][waddr], wdata, wbe);
        mem[1][waddr] = merged(mem[1][waddr], wdata, wbe);
      end
    end else begin
      for (int p = 0; p < 4; p++) exp_rv[p] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (rv[p] !== exp_rv[p]) begin
          n_fail++;
          $display("FAIL model rvalid[%0d] at %0t: got %b want %b", p, $time, rv[p], exp_rv[p]);
        end
        n_tests++;
        if (rd[p] !== exp_rd[p]) begin
          n_fail++;
          $display("FAIL model rdata[%0d] at %0t: got %h want %h", p, $time, rd[p], exp_rd[p]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle();
    we = 1'b0; re_a = 1'b0; re_b = 1'b0; on = 1'b1; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; on = 1'b1; we = 1'b1; re_a = 1'b1; re_b = 1'b1;
    waddr = 5'd9; wdata = 32'hFFFF_FFFF; wbe = 4'hF; raddr_a = 5'd9; raddr_b = 5'd9;
    @(negedge clk);
    step();
    lit("reset rdata_a", rd[0], 32'h0);
    lit("reset rvalid_a", {31'h0, rv[0]}, 32'h0);
    lit("reset rvalid_b", {31'h0, rv[1]}, 32'h0);
    check_en = 1'b1;

    // Read after reset.
    idle(); re_a = 1'b1; raddr_a = 5'd7;
    step();
    lit("t1 rdata_a", rd[0], 32'h0);
    lit("t1 rvalid_a", {31'h0, rv[0]}, 32'h1);

    // Full write then dual readback.
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; wbe = 4'hF;
    step();
    lit("t2 rvalid_a idle", {31'h0, rv[0]}, 32'h0);
    idle(); re_a = 1'b1; re_b = 1'b1; raddr_a = 5'd3; raddr_b = 5'd3;
    step();
    lit("t2 rdata_a", rd[0], 32'hDEAD_BEEF);
    lit("t2 rdata_b", rd[1], 32'hDEAD_BEEF);
    lit("t2 rvalid_b", {31'h0, rv[1]}, 32'h1);

    // Byte-lane write.
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h1122_3344; wbe = 4'b0101;
    step();
    idle(); re_a = 1'b1; raddr_a = 5'd3;
    step();
    lit("t3 lanes", rd[0], 32'hDE22_BE44);

    // WBE=0 write is a no-op.
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h0; wbe = 4'b0000;
    step();
    idle(); re_b = 1'b1; raddr_b = 5'd3;
    step();
    lit("wbe0 noop", rd[1], 32'hDE22_BE44);

    // Zero register vs plain entry 0.
    idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
    step();
    idle(); re_a = 1'b1; raddr_a = 5'd0;
    step();
    lit("t4 zero reg", rd[0], 32'h0);
    lit("t4 plain reg0", rd[2], 32'hFFFF_FFFF);

    // Same-cycle read/write to address 5.
    idle(); we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_0000; wbe = 4'hF;
    step();
    idle(); we = 1'b1; waddr = 5'd5; wdata = 32'h0000_BBBB; wbe = 4'b0011;
    re_a = 1'b1; raddr_a = 5'd5;
    step();
`ifdef REG_FILE_BYPASS_EN
    lit("t5 collide", rd[0], 32'hAAAA_BBBB);
`else
    lit("t5 collide", rd[0], 32'hAAAA_0000);
`endif
    idle(); re_a = 1'b1; raddr_a = 5'd5;
    step();
    lit("t5 after", rd[0], 32'hAAAA_BBBB);

    // ON=0 freezes everything.
    idle(); on = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; wbe = 4'hF;
    re_a = 1'b1; raddr_a = 5'd3;
    step();
    lit("t6 hold rdata", rd[0], 32'hAAAA_BBBB);
    lit("t6 rvalid off", {31'h0, rv[0]}, 32'h0);
    idle(); re_a = 1'b1; raddr_a = 5'd5;
    step();
    lit("t6 storage kept", rd[0], 32'hAAAA_BBBB);

    // Distinct addresses on the two ports, several patterns.
    for (int i = 1; i < 6; i++) begin
      idle(); we = 1'b1; waddr = 5'(8 + i); wdata = 32'h0101_0101 * (i + 16);
      wbe = 4'(i * 3);
      step();
    end
    for (int i = 1; i < 6; i++) begin
      idle(); re_a = 1'b1; re_b = 1'b1; raddr_a = 5'(8 + i); raddr_b = 5'(14 - i);
      step();
    end
    lit("pattern a13", rd[0], 32'h1515_1515);
    lit("pattern b9", rd[1], 32'h0000_1111);

    // Reset in the same cycle as a read request.
    idle(); re_a = 1'b1; re_b = 1'b1; raddr_a = 5'd5; raddr_b = 5'd3; rst_n = 1'b0;
    step();
    lit("t6 rst rvalid", {31'h0, rv[0]}, 32'h0);
    lit("t6 rst rdata", rd[0], 32'h0);
    idle(); re_a = 1'b1; raddr_a = 5'd5;
    step();
    lit("post-rst storage", rd[0], 32'h0);

    idle();
    step();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
